fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Control sequencer for the fetch stage. Generates Stall, FetchStall, Halt,
//   NotBranchOrJump and TruePC from execute/decode/memory events. Sits beside
//   Fetch in the CPU top level:
//   - registers branch/jump redirects;
//   - squashes wrong-path instructions;
//   - drains the pipeline on HALT, then parks the PC at 0 until restarted.
// PARAMETERS
//   DRAIN_CYCLES  3  cycles from halt_req until Halt pulses (in-flight retire)
//   START_HALTED  0  1: leave reset in HALTED and wait for start; 0: RUN
//   CNT_W         16 width of the saturating performance counters
// PORTS
//   clk              in   1      clock
//   rst              in   1      synchronous reset, active-low
//   hazard_stall     in   1      load-use hazard from decode
//   mem_stall        in   1      data-memory busy; freezes the whole pipe
//   branch_taken     in   1      execute resolved a taken branch/jump (1-cycle pulse)
//   branch_target    in   16     target PC, valid with branch_taken
//   halt_req         in   1      HALT decoded (1-cycle pulse)
//   start            in   1      leave HALTED (1-cycle pulse)
//   Stall            out  1      global pipeline freeze
//   FetchStall       out  1      freeze PC and fetch register only
//   Halt             out  1      1-cycle pulse; Fetch resets PC to 0
//   NotBranchOrJump  out  1      0 selects TruePC as the fetch address
//   TruePC           out  16     registered redirect target
//   Flush            out  1      squash fetch/decode pipeline registers
//   halted           out  1      state == HALTED
//   stall_cnt        out  CNT_W  cycles with Stall|FetchStall outside HALTED
//   redirect_cnt     out  CNT_W  redirects applied
// BEHAVIOUR
//   States: RUN, REDIRECT, DRAIN, HALTED (2-bit). All outputs come from state
//   and registers, except Stall, which also ORs the live stall inputs.
//   Reset (rst==0 at clk edge):
//   - state = START_HALTED ? HALTED : RUN; target_q = 0; counters = 0;
//     drain_cnt = 0.
//   - Outputs: Stall=0, FetchStall=START_HALTED, Halt=0, NotBranchOrJump=1,
//     TruePC=0, Flush=0.
//   RUN:
//   - Stall = hazard_stall | mem_stall.
//   - Event priority: branch_taken > halt_req > stalls.
//   - branch_taken: target_q <= branch_target; Flush=1 in the same cycle;
//     next state REDIRECT.
//   - halt_req (no branch): drain_cnt <= DRAIN_CYCLES-1; next state DRAIN.
//   REDIRECT:
//   - NotBranchOrJump=0, TruePC=target_q, Flush=1.
//   - mem_stall=1: Stall=1; stay in REDIRECT with target held.
//   - Otherwise: redirect_cnt++; go to RUN next cycle. Latency is
//     branch_taken -> fetch from target in the following cycle.
//   - hazard_stall is ignored in REDIRECT because the wrong path is flushed.
//   - A second branch_taken in REDIRECT overwrites target_q and stays in
//     REDIRECT.
//   DRAIN:
//   - FetchStall=1; Stall=mem_stall.
//   - drain_cnt decrements only when mem_stall=0.
//   - At drain_cnt==0 with mem_stall=0: Halt=1 for this cycle; go to HALTED.
//   - branch_taken and halt_req are ignored (the PC is forced to 0 anyway).
//   HALTED:
//   - FetchStall=1, halted=1; counters frozen.
//   - start: go to RUN next cycle with FetchStall=0.
//   - branch_taken and halt_req are ignored.
//   Counters:
//   - Saturate at all-ones; no wrap.
//   - stall_cnt counts once per cycle regardless of how many causes are active.
//   Reset mid-operation: any state returns to the reset state in 1 cycle, and
//   a pending target is dropped.
// STRUCTURE
//   - Shared header fetch_defs.vh: state encodings FS_RUN/FS_REDIRECT/
//     FS_DRAIN/FS_HALTED and the 16-bit PC width.
//   - Sub-module sat_counter #(W), instantiated twice (increment enable,
//     synchronous active-low clear).
//   - FSM and output decode live in one file.
// TESTING
//   1. Reset with START_HALTED=0, then idle 5 cycles -> NotBranchOrJump=1,
//      Stall=0, Flush=0, counters 0.
//   2. branch_taken with target 0x0040 -> Flush=1 that cycle; next cycle
//      NotBranchOrJump=0, TruePC=0x0040; then RUN; redirect_cnt=1.
//   3. branch_taken with target 0x0010 while mem_stall is high for 3 cycles ->
//      REDIRECT held 3 cycles with Stall=1; TruePC stays 0x0010 until the
//      stall drops.
//   4. halt_req with mem_stall=1 for 2 of the drain cycles -> Halt pulses
//      exactly 5 cycles after halt_req (DRAIN_CYCLES=3); halted=1 afterwards.
//   5. In HALTED, drive branch_taken then start -> branch ignored;
//      FetchStall=0 the cycle after start.
//   6. Hold hazard_stall for 2^CNT_W+5 cycles -> stall_cnt = 0xFFFF.
//      Assert rst=0 mid-drain -> state RUN, all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch-stage control sequencer.
//   PC_W         width of program-counter values
//   pc_t         program-counter type
//   FS_*         sequencer state encodings (2-bit)
//   state_name() readable state name for debug printing

package fetch_sequencer_pkg;

   localparam int PC_W = 16;

   typedef logic [PC_W-1:0] pc_t;

   localparam logic [1:0] FS_RUN      = 2'd0;
   localparam logic [1:0] FS_REDIRECT = 2'd1;
   localparam logic [1:0] FS_DRAIN    = 2'd2;
   localparam logic [1:0] FS_HALTED   = 2'd3;

   function automatic string state_name(input logic [1:0] s);
      case (s)
         FS_RUN:      return "RUN";
         FS_REDIRECT: return "REDIRECT";
         FS_DRAIN:    return "DRAIN";
         default:     return "HALTED";
      endcase
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the CPU top level and the fetch sequencer.
// master: CPU side, drives the pipeline events and reads the controls.
// slave : the sequencer, reads the events and drives the controls.
//   hazard_stall, mem_stall        level stall causes
//   branch_taken, branch_target    redirect pulse + target
//   halt_req, start                halt / restart pulses
//   Stall, FetchStall, Halt, NotBranchOrJump, TruePC, Flush, halted
//                                  fetch-stage controls
//   stall_cnt, redirect_cnt        saturating performance counters
//   fsm_state                      current sequencer state (debug)
// There is no valid/ready handshake here: every event input is sampled on
// each rising clk edge, pulses are one cycle wide, and every output is valid
// for the whole cycle in which it is driven.

interface fetch_sequencer_if #(
   parameter int CNT_W = 16
);
   import fetch_sequencer_pkg::*;

   logic             hazard_stall;
   logic             mem_stall;
   logic             branch_taken;
   pc_t              branch_target;
   logic             halt_req;
   logic             start;
   logic             Stall;
   logic             FetchStall;
   logic             Halt;
   logic             NotBranchOrJump;
   pc_t              TruePC;
   logic             Flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;
   logic [1:0]       fsm_state;

   modport master (
      output hazard_stall, mem_stall, branch_taken, branch_target, halt_req, start,
      input  Stall, FetchStall, Halt, NotBranchOrJump, TruePC, Flush, halted,
             stall_cnt, redirect_cnt, fsm_state
   );

   modport slave (
      input  hazard_stall, mem_stall, branch_taken, branch_target, halt_req, start,
      output Stall, FetchStall, Halt, NotBranchOrJump, TruePC, Flush, halted,
             stall_cnt, redirect_cnt, fsm_state
   );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk    clock
//   rst    synchronous clear, active-low
//   en     count this cycle
//   count  current value

module fetch_sequencer_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control sequencer. Registers branch/jump redirects, squashes
// the wrong path, drains the pipe on HALT and parks the PC until restarted.
//   clk   clock
//   rst   synchronous reset, active-low
//   bus   fetch_sequencer_if.slave: stall/branch/halt/start events in,
//         Stall/FetchStall/Halt/NotBranchOrJump/TruePC/Flush/halted,
//         counters and fsm_state out
// Parameters:
//   DRAIN_CYCLES  cycles spent draining in-flight instructions before Halt
//   START_HALTED  1: leave reset parked in HALTED, 0: leave reset in RUN
//   CNT_W         performance counter width

module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int START_HALTED = 0,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.slave  bus
);

   localparam int         DW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [1:0] RESET_STATE = (START_HALTED != 0) ? FS_HALTED : FS_RUN;

   logic [1:0]    state, state_nx;
   pc_t           target_q, target_nx;
   logic [DW-1:0] drain_cnt, drain_nx;

   logic stall, fetch_stall, halt, nbj, flush;
   logic redirect_inc, stall_inc;

   always_comb begin
      state_nx     = state;
      target_nx    = target_q;
      drain_nx     = drain_cnt;
      stall        = 1'b0;
      fetch_stall  = 1'b0;
      halt         = 1'b0;
      nbj          = 1'b1;
      flush        = 1'b0;
      redirect_inc = 1'b0;

      case (state)
         FS_RUN: begin
            stall = bus.hazard_stall | bus.mem_stall;
            // A taken branch wins over a HALT decoded behind it: the HALT
            // is on the wrong path and gets squashed with it.
            if (bus.branch_taken) begin
               target_nx = bus.branch_target;
               flush     = 1'b1;
               state_nx  = FS_REDIRECT;
            end else if (bus.halt_req) begin
               drain_nx = DW'(DRAIN_CYCLES - 1);
               state_nx = FS_DRAIN;
            end
         end

         FS_REDIRECT: begin
            // hazard_stall is irrelevant here: the instructions causing it
            // are being flushed.
            nbj   = 1'b0;
            flush = 1'b1;
            stall = bus.mem_stall;
            if (bus.branch_taken) begin
               target_nx = bus.branch_target;
            end else if (!bus.mem_stall) begin
               redirect_inc = 1'b1;
               state_nx     = FS_RUN;
            end
         end

         FS_DRAIN: begin
            fetch_stall = 1'b1;
            stall       = bus.mem_stall;
            // Draining only progresses while memory lets the pipe advance.
            if (!bus.mem_stall) begin
               if (drain_cnt == '0) begin
                  halt     = 1'b1;
                  state_nx = FS_HALTED;
               end else begin
                  drain_nx = drain_cnt - DW'(1);
               end
            end
         end

         FS_HALTED: begin
            fetch_stall = 1'b1;
            if (bus.start) begin
               state_nx = FS_RUN;
            end
         end

         default: state_nx = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RESET_STATE;
         target_q  <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nx;
         target_q  <= target_nx;
         drain_cnt <= drain_nx;
      end
   end

   // One count per cycle however many stall causes overlap; HALTED is idle
   // time, not stall time.
   assign stall_inc = (stall | fetch_stall) && (state != FS_HALTED);

   fetch_sequencer_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_inc),
      .count (bus.stall_cnt)
   );

   fetch_sequencer_sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (redirect_inc),
      .count (bus.redirect_cnt)
   );

   assign bus.Stall           = stall;
   assign bus.FetchStall      = fetch_stall;
   assign bus.Halt            = halt;
   assign bus.NotBranchOrJump = nbj;
   assign bus.TruePC          = target_q;
   assign bus.Flush           = flush;
   assign bus.halted          = (state == FS_HALTED);
   assign bus.fsm_state       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with inline
// checks, then a randomized run compared against a behavioural model.

module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int CNT_W = 16;
   localparam int DRAIN = 3;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int W     = 6 + 16 + 2 * CNT_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

   fetch_sequencer #(
      .DRAIN_CYCLES (DRAIN),
      .START_HALTED (0),
      .CNT_W        (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- behavioural model ----------------
   // Tracks what the fetch stage is doing in plain terms: running, a
   // redirect waiting to be applied, draining with N cycles left, or parked.
   bit          m_pending, m_draining, m_parked;
   int          m_left;
   logic [15:0] m_target;
   int          m_stalls, m_redirects;

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic logic [W-1:0] model_outputs();
      logic s, fs, h, nbj, fl, hl;
      s = 0; fs = 0; h = 0; nbj = 1; fl = 0; hl = 0;
      if (m_parked) begin
         fs = 1; hl = 1;
      end else if (m_draining) begin
         fs = 1; s = bus.mem_stall; h = (m_left == 0) && !bus.mem_stall;
      end else if (m_pending) begin
         s = bus.mem_stall; nbj = 0; fl = 1;
      end else begin
         s = bus.hazard_stall | bus.mem_stall; fl = bus.branch_taken;
      end
      return {s, fs, h, nbj, fl, hl, m_target, CNT_W'(m_stalls), CNT_W'(m_redirects)};
   endfunction

   function automatic logic [W-1:0] dut_outputs();
      return {bus.Stall, bus.FetchStall, bus.Halt, bus.NotBranchOrJump, bus.Flush,
              bus.halted, bus.TruePC, bus.stall_cnt, bus.redirect_cnt};
   endfunction

   task automatic model_update();
      if (!rst) begin
         m_pending = 0; m_draining = 0; m_parked = 0; m_left = 0;
         m_target = 16'h0; m_stalls = 0; m_redirects = 0;
      end else if (m_parked) begin
         if (bus.start) m_parked = 0;
      end else if (m_draining) begin
         m_stalls = sat_inc(m_stalls);
         if (!bus.mem_stall) begin
            if (m_left == 0) begin
               m_draining = 0; m_parked = 1;
            end else begin
               m_left = m_left - 1;
            end
         end
      end else if (m_pending) begin
         if (bus.mem_stall) m_stalls = sat_inc(m_stalls);
         if (bus.branch_taken) m_target = bus.branch_target;
         else if (!bus.mem_stall) begin
            m_pending = 0; m_redirects = sat_inc(m_redirects);
         end
      end else begin
         if (bus.hazard_stall | bus.mem_stall) m_stalls = sat_inc(m_stalls);
         if (bus.branch_taken) begin
            m_target = bus.branch_target; m_pending = 1;
         end else if (bus.halt_req) begin
            m_draining = 1; m_left = DRAIN - 1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic h, input logic m, input logic br,
                        input logic [15:0] bt, input logic hr, input logic st);
      bus.hazard_stall  = h;
      bus.mem_stall     = m;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.halt_req      = hr;
      bus.start         = st;
   endtask

   task automatic idle();
      drive(0, 0, 0, 16'h0, 0, 0);
   endtask

   // Inputs change at posedge+1; checks happen at posedge+2.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // {Stall, FetchStall, Halt, NBJ, Flush, halted, TruePC, stall_cnt, redirect_cnt}
   localparam logic [W-1:0] RESET_VEC = {6'b000100, 16'h0, {CNT_W{1'b0}}, {CNT_W{1'b0}}};

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst = 1'b0;
      tick(); tick();
      #1;
      n_checks++;
      if (dut_outputs() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_outputs(), RESET_VEC);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #1;
      n_checks++;
      if (dut_outputs() !== RESET_VEC) begin
         n_fail++; $display("FAIL idle_outputs: got %h want %h", dut_outputs(), RESET_VEC);
      end
   endtask

   task automatic test_redirect();
      drive(0, 0, 1, 16'h0040, 0, 0);
      #1;
      n_checks++;
      if ({bus.Flush, bus.NotBranchOrJump} !== 2'b11) begin
         n_fail++; $display("FAIL redirect_same_cycle: flush/nbj got %b want 11", {bus.Flush, bus.NotBranchOrJump});
      end
      tick();
      idle();
      #1;
      n_checks++;
      if ({bus.NotBranchOrJump, bus.Flush, bus.TruePC} !== {2'b01, 16'h0040}) begin
         n_fail++; $display("FAIL redirect_apply: nbj/flush/pc got %b%b %h want 01 0040",
                            bus.NotBranchOrJump, bus.Flush, bus.TruePC);
      end
      tick();
      #1;
      n_checks++;
      if ({bus.NotBranchOrJump, bus.Flush, bus.redirect_cnt} !== {2'b10, CNT_W'(1)}) begin
         n_fail++; $display("FAIL redirect_return: nbj/flush %b%b cnt %0d want 10 cnt 1",
                            bus.NotBranchOrJump, bus.Flush, bus.redirect_cnt);
      end
   endtask

   task automatic test_redirect_mem_stall();
      drive(0, 0, 1, 16'h0010, 0, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 16'h0, 0, 0);
         #1;
         n_checks++;
         if ({bus.Stall, bus.NotBranchOrJump, bus.TruePC} !== {2'b10, 16'h0010}) begin
            n_fail++; $display("FAIL redirect_hold_%0d: stall/nbj %b%b pc %h want 10 0010",
                               k, bus.Stall, bus.NotBranchOrJump, bus.TruePC);
         end
         tick();
      end
      idle();
      #1;
      n_checks++;
      if ({bus.Stall, bus.NotBranchOrJump, bus.TruePC} !== {2'b00, 16'h0010}) begin
         n_fail++; $display("FAIL redirect_release: stall/nbj %b%b pc %h want 00 0010",
                            bus.Stall, bus.NotBranchOrJump, bus.TruePC);
      end
      tick();
      #1;
      n_checks++;
      if ({bus.NotBranchOrJump, bus.redirect_cnt, bus.stall_cnt} !== {1'b1, CNT_W'(2), CNT_W'(3)}) begin
         n_fail++; $display("FAIL redirect_counts: nbj %b redir %0d stall %0d want 1 2 3",
                            bus.NotBranchOrJump, bus.redirect_cnt, bus.stall_cnt);
      end
   endtask

   task automatic test_halt();
      int halt_at;
      int pulses;
      halt_at = 0;
      pulses  = 0;
      drive(0, 0, 0, 16'h0, 1, 0);
      #1;
      n_checks++;
      if ({bus.FetchStall, bus.Halt} !== 2'b00) begin
         n_fail++; $display("FAIL halt_req_cycle: fetchstall/halt got %b want 00", {bus.FetchStall, bus.Halt});
      end
      tick();
      // memory busy during the 2nd and 3rd drain cycles
      for (int k = 1; k <= 8; k++) begin
         drive(0, (k == 2 || k == 3), 0, 16'h0, 0, 0);
         #1;
         n_checks++;
         if ({bus.FetchStall, bus.Stall} !== {1'b1, (k <= 5) && (k == 2 || k == 3)}) begin
            n_fail++; $display("FAIL drain_cycle_%0d: fetchstall/stall got %b%b", k, bus.FetchStall, bus.Stall);
         end
         if (bus.Halt === 1'b1) begin
            pulses++;
            if (halt_at == 0) halt_at = k;
         end
         tick();
      end
      idle();
      #1;
      n_checks++;
      if (halt_at != 5 || pulses != 1) begin
         n_fail++; $display("FAIL halt_timing: pulse at cycle %0d count %0d want cycle 5 count 1", halt_at, pulses);
      end
      n_checks++;
      if ({bus.halted, bus.FetchStall, bus.stall_cnt} !== {2'b11, CNT_W'(8)}) begin
         n_fail++; $display("FAIL halted_state: halted/fs %b%b stall_cnt %0d want 11 8",
                            bus.halted, bus.FetchStall, bus.stall_cnt);
      end
   endtask

   task automatic test_halted_ignores();
      drive(0, 0, 1, 16'h1234, 1, 0);
      #1;
      n_checks++;
      if ({bus.Flush, bus.NotBranchOrJump} !== 2'b01) begin
         n_fail++; $display("FAIL halted_branch: flush/nbj got %b%b want 01", bus.Flush, bus.NotBranchOrJump);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if ({bus.halted, bus.TruePC} !== {1'b1, 16'h0010}) begin
         n_fail++; $display("FAIL halted_keeps: halted %b pc %h want 1 0010", bus.halted, bus.TruePC);
      end
      drive(0, 0, 0, 16'h0, 0, 1);
      #1;
      n_checks++;
      if (bus.FetchStall !== 1'b1) begin
         n_fail++; $display("FAIL start_cycle: fetchstall got %b want 1", bus.FetchStall);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if ({bus.FetchStall, bus.halted, bus.redirect_cnt} !== {2'b00, CNT_W'(2)}) begin
         n_fail++; $display("FAIL after_start: fs/halted %b%b redir %0d want 00 2",
                            bus.FetchStall, bus.halted, bus.redirect_cnt);
      end
      tick();
   endtask

   task automatic test_saturate_and_reset();
      drive(1, 0, 0, 16'h0, 0, 0);
      for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
      idle();
      #1;
      n_checks++;
      if (bus.stall_cnt !== {CNT_W{1'b1}}) begin
         n_fail++; $display("FAIL stall_saturate: got %h want %h", bus.stall_cnt, {CNT_W{1'b1}});
      end
      drive(0, 0, 0, 16'h0, 1, 0);
      tick();
      idle();
      tick();
      rst = 1'b0;
      tick();
      #1;
      n_checks++;
      if (dut_outputs() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_mid_drain: got %h want %h", dut_outputs(), RESET_VEC);
      end
      rst = 1'b1;
      tick();
      drive(0, 0, 1, 16'hBEEF, 0, 0);
      tick();
      idle();
      rst = 1'b0;
      tick();
      #1;
      n_checks++;
      if ({bus.NotBranchOrJump, bus.Flush, bus.TruePC} !== {2'b10, 16'h0000}) begin
         n_fail++; $display("FAIL reset_drops_target: nbj/flush %b%b pc %h want 10 0000",
                            bus.NotBranchOrJump, bus.Flush, bus.TruePC);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] got, exp;
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, 16'($urandom),
               $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
         #1;
         exp_q.push_back(model_outputs());
         got = dut_outputs();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_cycle_%0d: got %h want %h (state %s)",
                               i, got, exp, state_name(bus.fsm_state));
         end
         tick();
      end
      rst = 1'b1;
      idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_redirect();
      test_redirect_mem_stall();
      test_halt();
      test_halted_ignores();
      test_saturate_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
